// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter family.
// Also used by the legacy single-cycle round_robin block.
package wrr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int RR_CONV = 0;
    localparam int RR_MOD  = 1;

    // Wrap is an explicit compare so non-power-of-two N never visits N..2^M-1.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned n);
        return (ptr == n - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between N bus masters and the weighted round-robin arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface wrr_arbiter_if #(
    parameter int N = 8,
    parameter int W = 4,
    localparam int M = $clog2(N)
);

    logic           i_en;
    logic [N-1:0]   i_req;
    logic [N*W-1:0] i_weight;
    logic           i_done;
    logic [N-1:0]   o_gnt;
    logic [M-1:0]   o_gnt_id;
    logic           o_valid;
    logic [W-1:0]   o_credit;

    modport master (
        output i_en, i_req, i_weight, i_done,
        input  o_gnt, o_gnt_id, o_valid, o_credit
    );

    modport slave (
        input  i_en, i_req, i_weight, i_done,
        output o_gnt, o_gnt_id, o_valid, o_credit
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping through N-1 back to 0.
module rr_pick #(
    parameter int N = 8,
    localparam int M = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [M-1:0] i_ptr,
    output logic [M-1:0] o_idx,
    output logic         o_any
);

    // Walking offsets in increasing order and keeping only the first hit gives the priority order.
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        o_idx = '0;
        for (int off = 0; off < N; off++) begin
            idx = int'(i_ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && i_req[idx[M-1:0]]) begin
                found = 1'b1;
                o_idx = idx[M-1:0];
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: each grant lasts up to weight[winner] completed beats,
// ends early when the holder drops its request, and is always followed by one idle cycle.
module wrr_arbiter #(
    parameter int N    = 8,
    parameter int W    = 4,
    parameter int TYPE = 1,
    localparam int M   = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    wrr_arbiter_if.slave  bus
);

    import wrr_pkg::*;

    state_e         state_q;
    logic [M-1:0]   ptr_q;
    logic [M-1:0]   ptr_d;
    logic [N-1:0]   gnt_q;
    logic [N-1:0]   gnt_d;
    logic [M-1:0]   gnt_id_q;
    logic           valid_q;
    logic [W-1:0]   credit_q;
    logic [W-1:0]   credit_d;
    logic [M-1:0]   winner;
    logic           anyReq;
    logic           holderReq;
    logic           lastBeat;

    rr_pick #(.N(N)) u_pick (
        .i_req (bus.i_req),
        .i_ptr (ptr_q),
        .o_idx (winner),
        .o_any (anyReq)
    );

    // Credit loaded at the grant edge; a zero weight still earns one beat.
    always_comb begin
        credit_d = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == M'(i)) begin
                credit_d = bus.i_weight[i*W +: W];
            end
        end
        if (credit_d == '0) begin
            credit_d = W'(1);
        end
        gnt_d = {{(N-1){1'b0}}, 1'b1} << winner;
        if (TYPE == RR_CONV) begin
            ptr_d = M'(next_ptr(32'(ptr_q), N));
        end else begin
            ptr_d = M'(next_ptr(32'(winner), N));
        end
    end

    assign holderReq = bus.i_req[gnt_id_q];
    assign lastBeat  = bus.i_done && (credit_q == W'(1));

    // A request drop takes precedence over a done beat; both lead to the same release.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            valid_q  <= 1'b0;
            credit_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_en && anyReq) begin
                        state_q  <= GRANT;
                        gnt_q    <= gnt_d;
                        gnt_id_q <= winner;
                        valid_q  <= 1'b1;
                        credit_q <= credit_d;
                        ptr_q    <= ptr_d;
                    end
                end
                GRANT: begin
                    if (!holderReq || lastBeat) begin
                        state_q  <= IDLE;
                        gnt_q    <= '0;
                        gnt_id_q <= '0;
                        valid_q  <= 1'b0;
                        credit_q <= '0;
                    end else if (bus.i_done) begin
                        credit_q <= credit_q - W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_gnt    = gnt_q;
    assign bus.o_gnt_id = gnt_id_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_credit = credit_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: N=8 modified and conventional pointer modes,
// plus an N=5 instance for the non-power-of-two wrap.
module tb_wrr_arbiter;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    wrr_arbiter_if #(.N(8), .W(4)) busA ();
    wrr_arbiter_if #(.N(8), .W(4)) busB ();
    wrr_arbiter_if #(.N(5), .W(4)) busC ();

    wrr_arbiter #(.N(8), .W(4), .TYPE(1)) dutA (.i_clk(clk), .i_rstn(rstn), .bus(busA));
    wrr_arbiter #(.N(8), .W(4), .TYPE(0)) dutB (.i_clk(clk), .i_rstn(rstn), .bus(busB));
    wrr_arbiter #(.N(5), .W(4), .TYPE(1)) dutC (.i_clk(clk), .i_rstn(rstn), .bus(busC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the edge, so they are stable at the next one.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] req,
                                 input logic [31:0] weight, input logic done);
        busA.i_en     = en;
        busA.i_req    = req;
        busA.i_weight = weight;
        busA.i_done   = done;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkA(input string tag, input logic [7:0] gnt, input logic [2:0] id,
                          input logic valid, input logic [3:0] credit);
        checkOutput({tag, ".gnt"},    32'(busA.o_gnt),    32'(gnt));
        checkOutput({tag, ".id"},     32'(busA.o_gnt_id), 32'(id));
        checkOutput({tag, ".valid"},  32'(busA.o_valid),  32'(valid));
        checkOutput({tag, ".credit"}, 32'(busA.o_credit), 32'(credit));
    endtask

    initial begin
        logic       doneSeq   [6];
        logic [3:0] expCredit [6];
        int         g;
        int         expId;
        int         cIds  [3];
        int         cPtrs [3];

        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        applyStimulus(1'b0, 8'h00, 32'h11111111, 1'b0);
        busB.i_en = 1'b0; busB.i_req = 8'h00; busB.i_weight = 32'h11111111; busB.i_done = 1'b0;
        busC.i_en = 1'b0; busC.i_req = 5'h00; busC.i_weight = 20'h11111;    busC.i_done = 1'b0;

        repeat (2) step();
        checkA("reset", 8'h00, 3'd0, 1'b0, 4'd0);
        checkOutput("reset.ptr", 32'(dutA.ptr_q), 32'd0);
        rstn = 1'b1;

        // Two requesters, single-beat grants; weight[2]=0 must behave as 1.
        $display("[TB] alternating grants id0/id2");
        applyStimulus(1'b1, 8'b0000_0101, 32'h11111011, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            if (k % 2 == 0) begin
                expId = (k == 2) ? 2 : 0;
                checkA($sformatf("alt%0d", k), 8'(1 << expId), 3'(expId), 1'b1, 4'd1);
            end else begin
                checkA($sformatf("alt%0d", k), 8'h00, 3'd0, 1'b0, 4'd0);
            end
        end

        applyStimulus(1'b0, 8'b0000_0101, 32'h11111011, 1'b0);
        step();
        checkA("enOff", 8'h00, 3'd0, 1'b0, 4'd0);
        checkOutput("enOff.ptr", 32'(dutA.ptr_q), 32'd1);

        // Weight 3 with gapped done pulses; i_en dropped while holding.
        $display("[TB] weighted hold id3");
        applyStimulus(1'b1, 8'b0000_1000, 32'h11113111, 1'b0);
        step();
        checkA("w3.grant", 8'h08, 3'd3, 1'b1, 4'd3);
        checkOutput("w3.ptr", 32'(dutA.ptr_q), 32'd4);
        busA.i_en = 1'b0;
        doneSeq   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        expCredit = '{4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
        for (int k = 0; k < 6; k++) begin
            busA.i_done = doneSeq[k];
            step();
            if (k < 5) begin
                checkA($sformatf("w3.beat%0d", k), 8'h08, 3'd3, 1'b1, expCredit[k]);
            end else begin
                checkA("w3.release", 8'h00, 3'd0, 1'b0, 4'd0);
            end
        end
        busA.i_req  = 8'h00;
        busA.i_done = 1'b0;

        // Early release on request drop; weight change mid-grant must not reload credit.
        $display("[TB] request drop id5");
        applyStimulus(1'b1, 8'b0010_0000, 32'h11413111, 1'b0);
        step();
        checkA("drop.grant", 8'h20, 3'd5, 1'b1, 4'd4);
        busA.i_weight = 32'h11F13111;
        busA.i_done   = 1'b1;
        step();
        checkA("drop.done1", 8'h20, 3'd5, 1'b1, 4'd3);
        busA.i_req = 8'h00;
        step();
        checkA("drop.release", 8'h00, 3'd0, 1'b0, 4'd0);
        checkOutput("drop.ptr", 32'(dutA.ptr_q), 32'd6);
        applyStimulus(1'b0, 8'h00, 32'h11111111, 1'b0);

        // Conventional pointer: id0, then id7 seven times, then id0 after the wrap.
        $display("[TB] conventional pointer sweep");
        busB.i_en = 1'b1; busB.i_req = 8'b1000_0001; busB.i_done = 1'b1;
        for (int k = 0; k < 18; k++) begin
            step();
            g = k / 2;
            if (k % 2 == 0) begin
                expId = (g == 0 || g == 8) ? 0 : 7;
                checkOutput($sformatf("conv%0d.gnt", g), 32'(busB.o_gnt), 32'(1 << expId));
                checkOutput($sformatf("conv%0d.id", g), 32'(busB.o_gnt_id), 32'(expId));
                checkOutput($sformatf("conv%0d.ptr", g), 32'(dutB.ptr_q), 32'((g + 1) % 8));
            end else begin
                checkOutput($sformatf("conv%0d.idle", g), 32'(busB.o_valid), 32'd0);
            end
        end
        busB.i_en = 1'b0; busB.i_req = 8'h00; busB.i_done = 1'b0;

        // N=5: winner id4 wraps the pointer straight to 0.
        $display("[TB] N=5 wrap");
        busC.i_en = 1'b1; busC.i_req = 5'b10001; busC.i_done = 1'b1;
        cIds  = '{0, 4, 0};
        cPtrs = '{1, 0, 1};
        for (int k = 0; k < 6; k++) begin
            step();
            g = k / 2;
            if (k % 2 == 0) begin
                checkOutput($sformatf("n5.%0d.gnt", g), 32'(busC.o_gnt), 32'(1 << cIds[g]));
                checkOutput($sformatf("n5.%0d.id", g), 32'(busC.o_gnt_id), 32'(cIds[g]));
                checkOutput($sformatf("n5.%0d.ptr", g), 32'(dutC.ptr_q), 32'(cPtrs[g]));
            end else begin
                checkOutput($sformatf("n5.%0d.idle", g), 32'(busC.o_gnt), 32'd0);
            end
        end
        busC.i_en = 1'b0; busC.i_req = 5'h00; busC.i_done = 1'b0;

        // Reset between edges clears a live grant at once; first grant afterwards is id0.
        $display("[TB] async reset mid-grant");
        applyStimulus(1'b1, 8'hFF, 32'h11111111, 1'b0);
        step();
        checkA("areset.grant", 8'h40, 3'd6, 1'b1, 4'd1);
        #3 rstn = 1'b0;
        #1;
        checkA("areset.now", 8'h00, 3'd0, 1'b0, 4'd0);
        checkOutput("areset.ptr", 32'(dutA.ptr_q), 32'd0);
        step();
        rstn = 1'b1;
        step();
        checkA("areset.first", 8'h01, 3'd0, 1'b1, 4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
Parametrised weighted round-robin arbiter. It is the successor to the single-cycle round_robin arbiter.
- Each grant is held for up to a programmable number of beats (per-requester weight), instead of one cycle.
- The grant is released early if the winner drops its request.
- Supports both pointer-update modes (conventional / modified) and any N >= 2, including non-power-of-two.
- Sits between N bus masters and a shared resource; the resource signals each completed beat on i_done.

Parameters:
N, 8, number of requesters (>= 2, need not be a power of two)
W, 4, width of each per-requester weight / credit counter
TYPE, 1, pointer update: 0 = conventional (ptr+1 per arbitration), 1 = modified (winner+1)
M, $clog2(N) (localparam), pointer / grant-index width

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_en  in  1  arbitration enable; arbitration happens only when high
i_req  in  N  request vector, bit i = requester i
i_weight  in  N*W  weights; requester i uses bits [i*W +: W]; quasi-static
i_done  in  1  current grant holder completed one beat this cycle
o_gnt  out  N  one-hot (or zero) registered grant vector
o_gnt_id  out  M  index of current grant holder; 0 when o_valid low
o_valid  out  1  high while a grant is held (o_gnt != 0)
o_credit  out  W  beats remaining for current holder; 0 when idle

Behaviour:
- Reset (async, i_rstn=0): o_gnt=0, o_gnt_id=0, o_valid=0, o_credit=0, ptr=0, FSM=IDLE. Effective immediately, mid-grant included. First arbitration can occur on the first rising edge after release.
- FSM states: IDLE, GRANT.
- IDLE, edge with i_en=1 and |i_req:
  - winner = first set bit of i_req searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - o_gnt = onehot(winner), o_gnt_id = winner, o_valid = 1.
  - o_credit = weight[winner]; a weight of 0 is treated as 1.
  - FSM -> GRANT. Latency: request sampled at edge k, grant visible after edge k.
- IDLE with i_en=0 or i_req=0: outputs stay zero, ptr unchanged.
- Pointer update, once per arbitration (at the grant edge):
  - TYPE0: ptr = (ptr+1) mod N.
  - TYPE1: ptr = (winner+1) mod N.
  - Wrap: N-1 -> 0, explicit compare, no reliance on M-bit overflow.
- GRANT, each edge:
  - i_req[holder]=0 -> release: FSM -> IDLE, all outputs zero, regardless of credit or i_done.
  - else if i_done=1 and o_credit=1 -> release, same as above.
  - else if i_done=1 -> o_credit decrements by 1, grant held.
  - else -> hold, no change.
- i_en is ignored in GRANT; it gates only new arbitration.
- Release always inserts exactly one idle cycle. Re-arbitration occurs on the following edge from IDLE, using the already-updated ptr.
- Simultaneous i_done=1 and request drop: request drop wins (same result, release).
- A winner that still requests after exhausting its credit is not re-granted ahead of others. The updated ptr gives the others priority (TYPE1 guarantees this).
- i_weight changes during GRANT do not affect the loaded credit.
- Invariants: o_gnt is one-hot or zero; o_gnt is nonzero only for a bit set in i_req at the grant edge; o_valid == |o_gnt.

Decomposition:
- Package wrr_pkg:
  - FSM state enum (IDLE, GRANT).
  - TYPE encodings (RR_CONV=0, RR_MOD=1).
  - Function next_ptr(ptr, N) for mod-N increment.
- Sub-module rr_pick:
  - Combinational: i_req, ptr -> winner index plus any-valid.
  - Parametrised N; reusable by the legacy round_robin block.

Test Plan:
1. Reset then N=8, TYPE1, all weights=1, i_en=1, i_req=8'b0000_0101, i_done=1 every cycle -> grants alternate id0, id2, id0 ..., one idle cycle between grants, o_credit=1 at each grant.
2. Weight[3]=3, i_req=8'b0000_1000, i_done pulsed high 3 cycles with gaps -> o_credit 3->2->1, release after the 3rd i_done, o_gnt=0 the next cycle.
3. Grant held for id5 with credit 4, i_req[5] dropped after 1 done -> release on that edge, o_credit=0, ptr=6 (TYPE1).
4. TYPE0, i_req=8'b1000_0001 constant, weights=1 -> ptr advances 1 per arbitration; grants id0, id7, id7, ..., id7, then id0 when ptr wraps 7->0. Cross-check against a TB reference model.
5. N=5 (non-power-of-two), TYPE1, i_req=5'b10001, winner id4 -> ptr wraps to 0, next grant id0; ptr never reaches 5-7.
6. Async reset asserted mid-GRANT, between edges -> o_gnt, o_valid, o_credit zero immediately. After release with i_req=8'hFF, first grant is id0.
